// File: rtl/instr_encoder_loader_pkg.sv
// Shared encoder definitions: MIPS opcode/funct fields, mnemonic codes, error codes, FSM states.
package instr_encoder_loader_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  typedef enum logic [3:0] {
    MN_ADD  = 4'd0,
    MN_SUB  = 4'd1,
    MN_AND  = 4'd2,
    MN_OR   = 4'd3,
    MN_ADDI = 4'd4,
    MN_ORI  = 4'd5,
    MN_LW   = 4'd6,
    MN_SW   = 4'd7,
    MN_BEQ  = 4'd8,
    MN_J    = 4'd9
  } mnem_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_MNEM  = 2'd1,
    ERR_RANGE = 2'd2
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0]  mnem;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [31:0] target;
  } req_t;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational mnemonic+fields+pc -> 32-bit MIPS word, plus legality flags.
// Define ENC_RANGE_CHECK_EN to flag misaligned/out-of-range BEQ and J targets.
module instr_field_packer
  import instr_encoder_loader_pkg::*;
(
  input  req_t        req_i,
  input  logic [31:0] pc_i,
  output logic [31:0] word_o,
  output logic        unsupported_o,
  output logic        range_err_o
);

  logic [31:0] pc4;
  logic [15:0] br_off;

  assign pc4    = pc_i + 32'd4;
  // Low 16 bits are identical for logical and arithmetic shift.
  assign br_off = 16'((req_i.target - pc4) >> 2);

  always_comb begin
    word_o        = '0;
    unsupported_o = 1'b0;
    range_err_o   = 1'b0;
    case (mnem_e'(req_i.mnem))
      MN_ADD:  word_o = r_word(req_i.rs, req_i.rt, req_i.rd, FN_ADD);
      MN_SUB:  word_o = r_word(req_i.rs, req_i.rt, req_i.rd, FN_SUB);
      MN_AND:  word_o = r_word(req_i.rs, req_i.rt, req_i.rd, FN_AND);
      MN_OR:   word_o = r_word(req_i.rs, req_i.rt, req_i.rd, FN_OR);
      MN_ADDI: word_o = {OP_ADDI, req_i.rs, req_i.rt, req_i.imm};
      MN_ORI:  word_o = {OP_ORI,  req_i.rs, req_i.rt, req_i.imm};
      MN_LW:   word_o = {OP_LW,   req_i.rs, req_i.rt, req_i.imm};
      MN_SW:   word_o = {OP_SW,   req_i.rs, req_i.rt, req_i.imm};
      MN_BEQ: begin
        word_o = {OP_BEQ, req_i.rs, req_i.rt, br_off};
`ifdef ENC_RANGE_CHECK_EN
        // Byte distance must lie in [-2^17, 2^17-1] for the word offset to fit 16 bits.
        range_err_o = (req_i.target[1:0] != 2'b00)
                   || ($signed(req_i.target - pc4) < -32'sd131072)
                   || ($signed(req_i.target - pc4) >  32'sd131071);
`endif
      end
      MN_J: begin
        word_o = {OP_J, req_i.target[27:2]};
`ifdef ENC_RANGE_CHECK_EN
        range_err_o = (req_i.target[1:0] != 2'b00) || (req_i.target[31:28] != pc4[31:28]);
`endif
      end
      default: unsupported_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes field-level instruction requests and writes them sequentially into instruction memory.
// IDLE -> ENC -> WR handshake; optional target range checking via ENC_RANGE_CHECK_EN.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [31:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ack,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] PTR_MAX  = {ADDR_W{1'b1}};

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              err_q, err_d;
  err_code_e         code_q, code_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [31:0] pk_word;
  logic        pk_unsup, pk_range;
  logic [31:0] pc;

  assign pc = {{(30-ADDR_W){1'b0}}, ptr_q, 2'b00};

  instr_field_packer u_packer (
    .req_i         (req_q),
    .pc_i          (pc),
    .word_o        (pk_word),
    .unsupported_o (pk_unsup),
    .range_err_o   (pk_range)
  );

  assign in_ready   = (state_q == ST_IDLE) && !full_q && !start;
  assign imem_we    = (state_q == ST_WR);
  assign imem_addr  = ptr_q;
  assign imem_wdata = wdata_q;
  assign count      = cnt_q;
  assign full       = full_q;
  assign err        = err_q;
  assign err_code   = code_q;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    err_d   = err_q;
    code_d  = code_q;
    wdata_d = wdata_q;
    if (start) begin
      state_d = ST_IDLE;
      ptr_d   = BASE_PTR;
      cnt_d   = '0;
      full_d  = 1'b0;
      err_d   = 1'b0;
      code_d  = ERR_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            req_d   = '{mnem: in_mnem, rs: in_rs, rt: in_rt, rd: in_rd,
                        imm: in_imm, target: in_target};
            state_d = ST_ENC;
          end
        end
        ST_ENC: begin
          if (pk_unsup || pk_range) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            // Only the first error since start is reported.
            if (!err_q) code_d = pk_unsup ? ERR_MNEM : ERR_RANGE;
          end else begin
            wdata_d = pk_word;
            state_d = ST_WR;
          end
        end
        ST_WR: begin
          if (imem_ack) begin
            state_d = ST_IDLE;
            cnt_d   = cnt_q + (ADDR_W+1)'(1);
            if (ptr_q == PTR_MAX) full_d = 1'b1;
            else                  ptr_d  = ptr_q + ADDR_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      ptr_q   <= BASE_PTR;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      err_q   <= err_d;
      code_q  <= code_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader (ADDR_W=2): memory responder pops expected writes.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_mnem;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [31:0] in_target;
  logic        imem_we;
  logic [1:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        imem_ack;
  logic [2:0]  count;
  logic        full;
  logic        err;
  logic [1:0]  err_code;

  int n_chk  = 0;
  int n_pass = 0;

  logic [33:0] sb[$];
  logic [1:0]  exp_ptr = 2'd0;
  int          ack_delay = 0;
  bit          ack_en = 1'b1;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .in_target(in_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_ack(imem_ack),
    .count(count), .full(full), .err(err), .err_code(err_code)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("rdy_wait", {31'd0, in_ready}, 32'd1);
  endtask

  // exp_lat > 0: wait for in_ready to return and check the accept-to-ready latency.
  task automatic send(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [31:0] tgt,
                      input bit legal, input logic [31:0] w, input int exp_lat);
    int lat;
    wait_ready();
    in_valid = 1'b1; in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd;
    in_imm = imm; in_target = tgt;
    if (legal) begin
      sb.push_back({exp_ptr, w});
      exp_ptr = exp_ptr + 2'd1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (exp_lat > 0) begin
      lat = 1;
      while (!in_ready && lat < 60) begin
        @(negedge clk);
        lat++;
      end
      chk("latency", lat, exp_lat);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_ptr = 2'd0;
  endtask

  // Memory model: compares each new write with the scoreboard, checks hold stability.
  initial begin
    logic [33:0] e;
    logic [1:0]  cap_addr;
    logic [31:0] cap_data;
    int          wcyc;
    imem_ack = 1'b0;
    wcyc = 0;
    cap_addr = '0;
    cap_data = '0;
    forever begin
      @(negedge clk);
      imem_ack = 1'b0;
      if (imem_we) begin
        if (wcyc == 0) begin
          chk("wr_pending", sb.size(), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("wr_addr", {30'd0, imem_addr}, {30'd0, e[33:32]});
            chk("wr_data", imem_wdata, e[31:0]);
          end
          cap_addr = imem_addr;
          cap_data = imem_wdata;
        end else begin
          chk("hold_addr", {30'd0, imem_addr}, {30'd0, cap_addr});
          chk("hold_data", imem_wdata, cap_data);
          chk("hold_rdy", {31'd0, in_ready}, 32'd0);
        end
        if (ack_en && wcyc >= ack_delay) begin
          imem_ack = 1'b1;
          wcyc = 0;
        end else wcyc++;
      end else wcyc = 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_mnem = '0;
    in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_we",    {31'd0, imem_we},    32'd0);
    chk("rst_addr",  {30'd0, imem_addr},  32'd0);
    chk("rst_wdata", imem_wdata,          32'd0);
    chk("rst_count", {29'd0, count},      32'd0);
    chk("rst_full",  {31'd0, full},       32'd0);
    chk("rst_err",   {31'd0, err},        32'd0);
    chk("rst_code",  {30'd0, err_code},   32'd0);

    // Fill all four locations.
    send(4'd4, 5'd0, 5'd1, 5'd0, 16'd5, 32'd0, 1'b1, 32'h20010005, 3);
    chk("count1", {29'd0, count}, 32'd1);
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 32'd0, 1'b1, 32'h00221820, 3);
    ack_delay = 4;
    send(4'd6, 5'd1, 5'd4, 5'd0, 16'd8, 32'd0, 1'b1, 32'h8C240008, 7);
    ack_delay = 0;
    chk("count3", {29'd0, count}, 32'd3);
    send(4'd8, 5'd1, 5'd2, 5'd0, 16'd0, 32'h0, 1'b1, 32'h1022FFFC, 0);
    repeat (3) @(negedge clk);
    chk("full_set",   {31'd0, full},      32'd1);
    chk("full_count", {29'd0, count},     32'd4);
    chk("full_ptr",   {30'd0, imem_addr}, 32'd3);

    // Requests while full must be refused.
    in_valid = 1'b1; in_mnem = 4'd4;
    for (int i = 0; i < 3; i++) begin
      chk("full_rdy", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;

    pulse_start();
    chk("st_full",  {31'd0, full},      32'd0);
    chk("st_count", {29'd0, count},     32'd0);
    chk("st_ptr",   {30'd0, imem_addr}, 32'd0);

    send(4'd9, 5'd0, 5'd0, 5'd0, 16'd0, 32'h40, 1'b1, 32'h08000010, 3);
`ifdef ENC_RANGE_CHECK_EN
    send(4'd8, 5'd1, 5'd2, 5'd0, 16'd0, 32'h00040002, 1'b0, 32'h0, 2);
    chk("rng_err",   {31'd0, err},      32'd1);
    chk("rng_code",  {30'd0, err_code}, 32'd2);
    chk("rng_count", {29'd0, count},    32'd1);
`else
    send(4'd8, 5'd1, 5'd2, 5'd0, 16'd0, 32'h00040002, 1'b1, 32'h1022FFFE, 3);
    chk("rng_err",   {31'd0, err},      32'd0);
    chk("rng_count", {29'd0, count},    32'd2);
`endif

    // start and in_valid together: start wins.
    start = 1'b1; in_valid = 1'b1; in_mnem = 4'd4; in_imm = 16'h1234;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; exp_ptr = 2'd0;
    repeat (4) @(negedge clk);
    chk("sv_count", {29'd0, count},   32'd0);
    chk("sv_we",    {31'd0, imem_we}, 32'd0);
    chk("sv_err",   {31'd0, err},     32'd0);

    // Unsupported mnemonics: sticky error, first code kept.
    send(4'd12, 5'd1, 5'd1, 5'd1, 16'd0, 32'd0, 1'b0, 32'h0, 2);
    chk("um_err",   {31'd0, err},      32'd1);
    chk("um_code",  {30'd0, err_code}, 32'd1);
    chk("um_ptr",   {30'd0, imem_addr}, 32'd0);
    chk("um_count", {29'd0, count},    32'd0);
    send(4'd1, 5'd4, 5'd5, 5'd6, 16'd0, 32'd0, 1'b1, 32'h00853022, 3);
    send(4'd15, 5'd0, 5'd0, 5'd0, 16'd0, 32'd0, 1'b0, 32'h0, 2);
    send(4'd5, 5'd2, 5'd3, 5'd0, 16'hABCD, 32'd0, 1'b1, 32'h3443ABCD, 3);
    chk("um_err2",   {31'd0, err},      32'd1);
    chk("um_code2",  {30'd0, err_code}, 32'd1);
    chk("um_count2", {29'd0, count},    32'd2);

    // Abort a write whose ack never comes.
    ack_en = 1'b0;
    send(4'd3, 5'd7, 5'd8, 5'd9, 16'd0, 32'd0, 1'b1, 32'h00E84825, 0);
    n = 0;
    while (!imem_we && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ab_we_up", {31'd0, imem_we}, 32'd1);
    repeat (2) @(negedge clk);
    pulse_start();
    ack_en = 1'b1;
    chk("ab_we",    {31'd0, imem_we},   32'd0);
    chk("ab_ptr",   {30'd0, imem_addr}, 32'd0);
    chk("ab_count", {29'd0, count},     32'd0);
    chk("ab_full",  {31'd0, full},      32'd0);
    chk("ab_err",   {31'd0, err},       32'd0);
    chk("ab_code",  {30'd0, err_code},  32'd0);

    send(4'd2, 5'd1, 5'd1, 5'd1, 16'd0, 32'd0, 1'b1, 32'h00210824, 3);
    send(4'd7, 5'd29, 5'd31, 5'd0, 16'hFFFC, 32'd0, 1'b1, 32'hAFBFFFFC, 3);
    chk("end_count", {29'd0, count}, 32'd2);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
